multi_wav_player: RTL and testbench

// Multi-channel PCM sample player. Successor to the single-channel 8 kHz player.
// N channels share one synchronous sample ROM through a time-multiplexed fetch

---
 rtl/multi_wav_player.sv | 176 +++++++++++++++++
 tb/tb_multi_wav_player.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_wav_player.sv
// multi_wav_player -- multi-channel PCM sample player.
//
// CHANNELS voices share one synchronous sample ROM. A fetch sequencer walks
// the channels once per sample tick. The captured samples are scaled by
// their per-channel volume, summed, and saturated into one unsigned output.
//
// Ports
//   clk_sys        system clock
//   reset_n        synchronous, active-low reset
//   trig[c]        one-cycle start pulse: restart channel c at offset 0
//   stop[c]        one-cycle stop pulse: silence channel c; wins over trig
//   loop[c]        1 = wrap to offset 0 at end, 0 = one-shot
//   vol[4c+:4]     channel gain 0..15, sampled live
//   rom_a          registered ROM address {channel, offset}
//   rom_d          ROM data, valid one cycle after rom_a is presented
//   audio_out      mixed, saturated sample; holds between updates
//   sample_strobe  one-cycle pulse when audio_out updates
//   playing[c]     channel c active flag
module multi_wav_player #(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 8,
    parameter int OUT_W    = 16,
    parameter int PRESCALE = 2178,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [CHANNELS-1:0]    trig,
    input  logic [CHANNELS-1:0]    stop,
    input  logic [CHANNELS-1:0]    loop,
    input  logic [4*CHANNELS-1:0]  vol,
    output logic [CW+ADDR_W-1:0]   rom_a,
    input  logic [DATA_W-1:0]      rom_d,
    output logic [OUT_W-1:0]       audio_out,
    output logic                   sample_strobe,
    output logic [CHANNELS-1:0]    playing
);

    localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SUM_W = OUT_W + CW;
    localparam int SHIFT = OUT_W - DATA_W - 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_MIX  = 2'd3;

    // Parameter sanity is checked at elaboration so a bad build fails early.
    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("multi_wav_player: CHANNELS must be 1..8");
    end
    if (OUT_W < DATA_W + 4) begin : g_bad_out_w
        $error("multi_wav_player: OUT_W must be >= DATA_W+4");
    end
    if (PRESCALE <= 2 * CHANNELS + 2) begin : g_bad_prescale
        $error("multi_wav_player: PRESCALE must exceed 2*CHANNELS+2");
    end

    logic [PW-1:0]     pcnt;
    logic              tick;
    logic [1:0]        state;
    logic [CW-1:0]     ch;
    // cap_en/cap_ch mark the cycle in which rom_d carries the word fetched
    // in the previous DATA state, and which channel it belongs to.
    logic              cap_en;
    logic [CW-1:0]     cap_ch;
    logic [DATA_W-1:0] cap_val;
    logic [DATA_W-1:0] sample [CHANNELS];
    logic [ADDR_W-1:0] off    [CHANNELS];

    logic [SUM_W-1:0]  mix_sum;
    logic [DATA_W-1:0] cur;
    logic [DATA_W+3:0] prod;
    logic [OUT_W-1:0]  audio_next;

    assign tick    = (pcnt == PW'(PRESCALE - 1));
    assign cap_val = playing[cap_ch] ? rom_d : '0;

    // The last channel is captured in the MIX cycle itself, so its term is
    // taken straight from rom_d rather than from the sample register.
    always_comb begin
        // NOTE: every comb output gets a default up front so no path leaves
        // it unassigned, which would infer a latch.
        mix_sum = '0;
        cur     = '0;
        prod    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cur     = (cap_en && (cap_ch == CW'(c))) ? cap_val : sample[c];
            prod    = (DATA_W + 4)'(cur) * (DATA_W + 4)'(vol[4*c +: 4]);
            mix_sum = mix_sum + (SUM_W'(prod) << SHIFT);
        end
    end

    assign audio_next = (|mix_sum[SUM_W-1:OUT_W]) ? '1 : mix_sum[OUT_W-1:0];

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            pcnt          <= '0;
            state         <= S_IDLE;
            ch            <= '0;
            cap_en        <= 1'b0;
            cap_ch        <= '0;
            rom_a         <= '0;
            audio_out     <= '0;
            sample_strobe <= 1'b0;
            playing       <= '0;
            // NOTE: the small per-channel arrays are reset explicitly; they
            // are a handful of flops, not a RAM, and a stale offset or
            // sample after reset would be audible.
            for (int c = 0; c < CHANNELS; c++) begin
                sample[c] <= '0;
                off[c]    <= '0;
            end
        end else begin
            // NOTE: all state here uses non-blocking assignment; later
            // assignments in this block (trig/stop) override earlier ones.
            pcnt          <= tick ? '0 : pcnt + 1'b1;
            sample_strobe <= 1'b0;
            cap_en        <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (tick) begin
                        state <= S_ADDR;
                        ch    <= '0;
                    end
                end
                S_ADDR: begin
                    rom_a <= {ch, off[ch]};
                    state <= S_DATA;
                end
                S_DATA: begin
                    cap_en <= 1'b1;
                    cap_ch <= ch;
                    if (ch == CW'(CHANNELS - 1)) begin
                        state <= S_MIX;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= S_ADDR;
                    end
                end
                default: begin
                    audio_out     <= audio_next;
                    sample_strobe <= 1'b1;
                    state         <= S_IDLE;
                end
            endcase

            for (int c = 0; c < CHANNELS; c++) begin
                if (cap_en && (cap_ch == CW'(c))) begin
                    sample[c] <= cap_val;
                    if (playing[c]) begin
                        if (off[c] != '1) begin
                            off[c] <= off[c] + 1'b1;
                        end else begin
                            off[c] <= '0;
                            if (!loop[c]) begin
                                playing[c] <= 1'b0;
                            end
                        end
                    end
                end
                // Control pulses take priority over the fetch advance.
                if (stop[c]) begin
                    playing[c] <= 1'b0;
                    off[c]     <= '0;
                end else if (trig[c]) begin
                    playing[c] <= 1'b1;
                    off[c]     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_wav_player.sv
// tb_multi_wav_player -- scoreboard bench for multi_wav_player.
//
// Two voices, 16-sample regions, 8-cycle sample period. The ROM model
// returns the low address bits (channel,offset) or a constant 8'hFF.
// Stimulus pushes hand-computed mix values into exp_q; the monitor pops
// one entry per sample_strobe while the queue holds entries.
module tb_multi_wav_player;

    localparam int CHANNELS = 2;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int OUT_W    = 16;
    localparam int PRESCALE = 8;
    localparam int FIRST_STROBE = PRESCALE + 2 * CHANNELS + 1;

    logic                  clk_sys;
    logic                  reset_n;
    logic [CHANNELS-1:0]   trig;
    logic [CHANNELS-1:0]   stop;
    logic [CHANNELS-1:0]   loop;
    logic [4*CHANNELS-1:0] vol;
    logic [ADDR_W:0]       rom_a;
    logic [DATA_W-1:0]     rom_d;
    logic [OUT_W-1:0]      audio_out;
    logic                  sample_strobe;
    logic [CHANNELS-1:0]   playing;
    logic                  rom_mode;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q [$];

    typedef struct {
        logic [3:0]  v0;
        logic [3:0]  v1;
        logic [15:0] exp;
    } sat_vec_t;

    sat_vec_t sat_tab [6];

    multi_wav_player #(
        .CHANNELS (CHANNELS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .OUT_W    (OUT_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .trig          (trig),
        .stop          (stop),
        .loop          (loop),
        .vol           (vol),
        .rom_a         (rom_a),
        .rom_d         (rom_d),
        .audio_out     (audio_out),
        .sample_strobe (sample_strobe),
        .playing       (playing)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Synchronous ROM, one cycle of read latency.
    always @(posedge clk_sys) begin
        rom_d <= rom_mode ? 8'hFF : {3'b000, rom_a};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each strobe against the oldest pending expectation.
    always @(posedge clk_sys) begin
        #1;
        if (sample_strobe && exp_q.size() > 0) begin
            check("audio_out", 32'(audio_out), 32'(exp_q.pop_front()));
        end
    end

    // Returns at the negedge of the next cycle showing sample_strobe.
    task automatic wait_strobe();
        int n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!sample_strobe && n < 64);
        check("strobe_seen", 32'(sample_strobe), 32'd1);
    endtask

    task automatic pulse(input logic [CHANNELS-1:0] t, input logic [CHANNELS-1:0] s);
        trig = t;
        stop = s;
        @(negedge clk_sys);
        trig = '0;
        stop = '0;
    endtask

    // Called at the negedge of the first cycle after the last reset edge.
    task automatic measure_first_strobe();
        int n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!sample_strobe && n < 100);
        check("first_strobe_cycle", 32'(n), 32'(FIRST_STROBE));
        check("first_strobe_audio", 32'(audio_out), 32'd0);
        check("first_strobe_playing", 32'(playing), 32'd0);
    endtask

    function automatic logic [15:0] ch0_val(input int k);
        return 16'((k * 15) << 4);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sat_tab = '{
            '{4'd15, 4'd8, 16'hFFFF},
            '{4'd8,  4'd8, 16'hFF00},
            '{4'd8,  4'd0, 16'h7F80},
            '{4'd0,  4'd0, 16'h0000},
            '{4'd8,  4'd9, 16'hFFFF},
            '{4'd7,  4'd8, 16'hEF10}
        };

        // 1: reset with trig held high.
        reset_n  = 1'b0;
        trig     = '1;
        stop     = '0;
        loop     = '0;
        vol      = '0;
        rom_mode = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("reset_playing", 32'(playing), 32'd0);
        check("reset_audio", 32'(audio_out), 32'd0);
        check("reset_strobe", 32'(sample_strobe), 32'd0);
        check("reset_rom_a", 32'(rom_a), 32'd0);
        trig    = '0;
        reset_n = 1'b1;
        measure_first_strobe();

        // 2: one-shot on ch0, 16 samples then silence.
        vol  = {4'd0, 4'd15};
        loop = 2'b00;
        wait_strobe();
        pulse(2'b01, 2'b00);
        check("oneshot_start_playing", 32'(playing), 32'd1);
        for (int k = 0; k < 16; k++) exp_q.push_back(ch0_val(k));
        exp_q.push_back(16'h0000);
        for (int k = 1; k <= 16; k++) begin
            wait_strobe();
            if (k == 15) check("oneshot_playing_15", 32'(playing), 32'd1);
            if (k == 16) check("oneshot_playing_16", 32'(playing), 32'd0);
        end
        wait_strobe();

        // 3: looping ch0 for 40 samples.
        loop = 2'b01;
        pulse(2'b01, 2'b00);
        for (int k = 0; k < 40; k++) exp_q.push_back(ch0_val(k % 16));
        for (int k = 0; k < 40; k++) wait_strobe();
        check("loop_playing_40", 32'(playing), 32'd1);

        // 4: saturation, both voices full-scale, volume changed live.
        rom_mode = 1'b1;
        loop     = 2'b11;
        vol      = {4'd15, 4'd15};
        pulse(2'b11, 2'b00);
        exp_q.push_back(16'hFFFF);
        for (int i = 0; i < 6; i++) begin
            wait_strobe();
            vol = {sat_tab[i].v1, sat_tab[i].v0};
            exp_q.push_back(sat_tab[i].exp);
        end
        wait_strobe();
        check("sat_playing", 32'(playing), 32'd3);

        // 5: stop, stop+trig, retrigger.
        rom_mode = 1'b0;
        loop     = 2'b00;
        vol      = {4'd0, 4'd15};
        pulse(2'b01, 2'b10);
        check("stop_ch1_playing", 32'(playing), 32'd1);
        for (int k = 0; k < 6; k++) exp_q.push_back(ch0_val(k));
        for (int k = 0; k < 6; k++) wait_strobe();
        pulse(2'b01, 2'b01);
        check("stop_wins_playing", 32'(playing), 32'd0);
        exp_q.push_back(16'h0000);
        wait_strobe();
        pulse(2'b01, 2'b00);
        for (int k = 0; k < 9; k++) exp_q.push_back(ch0_val(k));
        repeat (3) @(negedge clk_sys);
        check("trig_rom_a", 32'(rom_a), 32'h00);
        for (int k = 0; k < 9; k++) wait_strobe();
        pulse(2'b01, 2'b00);
        for (int k = 0; k < 3; k++) exp_q.push_back(ch0_val(k));
        repeat (3) @(negedge clk_sys);
        check("retrig_rom_a", 32'(rom_a), 32'h00);
        for (int k = 0; k < 3; k++) wait_strobe();

        // 6: reset during DATA(1) while ch0 plays.
        loop = 2'b01;
        pulse(2'b01, 2'b00);
        for (int k = 0; k < 4; k++) exp_q.push_back(ch0_val(k));
        for (int k = 0; k < 4; k++) wait_strobe();
        repeat (6) @(negedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        check("midreset_audio", 32'(audio_out), 32'd0);
        check("midreset_strobe", 32'(sample_strobe), 32'd0);
        check("midreset_playing", 32'(playing), 32'd0);
        check("midreset_rom_a", 32'(rom_a), 32'd0);
        reset_n = 1'b1;
        measure_first_strobe();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
